i2c_client: RTL

I2C slave stage that sits directly downstream of the I2C master inside `server_client`. It receives the master's SCL/SDA and answers its address with ACKs. Write data bytes are shifted into the 32-bit `out` register that the top level exposes. Read transactions return the current `out` word byte-by-byte, so the master can check what it wrote.

---
 rtl/i2c_client.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_client.sv
// I2C slave for a fixed 7-bit address: write bytes shift into a 32-bit register,
// reads return that register byte-by-byte, MSB first.
module i2c_client #(
  parameter logic [6:0] ADDR = 7'h50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [31:0] out,
  output logic        word_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK
  } state_t;

  // ACK slot phases: wait for the fall ending bit 8, hold through the 9th rise,
  // then wait for the fall ending bit 9.
  typedef enum logic [1:0] {PH_WAIT_FALL, PH_DRIVE, PH_HOLD} ack_ph_t;

  logic        r_scl_s1, r_scl_s2, r_scl_d;
  logic        r_sda_s1, r_sda_s2, r_sda_d;

  state_t      r_state, w_state_nxt;
  ack_ph_t     r_ph, w_ph_nxt;
  logic [2:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_rw, w_rw_nxt;
  logic [1:0]  r_byte_cnt, w_byte_cnt_nxt;
  logic [31:0] r_tx, w_tx_nxt;
  logic        r_sda_oe, w_sda_oe_nxt;
  logic [31:0] r_out, w_out_nxt;
  logic        r_word_valid, w_word_valid_nxt;
  logic        r_busy, w_busy_nxt;

  logic        w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]  w_byte;
  logic [4:0]  w_rd_idx;

  // Synchronizers come out of reset at the idle-bus level so no false START
  // is decoded when the block leaves reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here make each flop sample the previous
      // stage's old value, which is what forms a real shift chain.
      r_scl_s1 <= scl;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_byte     = {r_shift[6:0], r_sda_s2};
  assign w_rd_idx   = 5'd31 - {2'b00, r_bit_cnt};

  always_comb begin
    // NOTE: every next-state value gets a default first so no path through
    // the case statement can leave one unassigned and infer a latch.
    w_state_nxt      = r_state;
    w_ph_nxt         = r_ph;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_nxt      = r_shift;
    w_rw_nxt         = r_rw;
    w_byte_cnt_nxt   = r_byte_cnt;
    w_tx_nxt         = r_tx;
    w_sda_oe_nxt     = r_sda_oe;
    w_out_nxt        = r_out;
    w_word_valid_nxt = 1'b0;
    w_busy_nxt       = r_busy;

    if (w_start) begin
      w_state_nxt    = S_ADDR;
      w_ph_nxt       = PH_WAIT_FALL;
      w_bit_cnt_nxt  = 3'd0;
      w_shift_nxt    = 8'h00;
      w_byte_cnt_nxt = 2'd0;
      w_sda_oe_nxt   = 1'b0;
    end else if (w_stop) begin
      w_state_nxt  = S_IDLE;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: ;

        S_ADDR: if (w_scl_rise) begin
          w_shift_nxt   = w_byte;
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            if (w_byte[7:1] == ADDR) begin
              w_state_nxt = S_ADDR_ACK;
              w_ph_nxt    = PH_WAIT_FALL;
              w_rw_nxt    = w_byte[0];
              w_busy_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
              w_busy_nxt  = 1'b0;
            end
          end
        end

        S_ADDR_ACK: unique case (r_ph)
          PH_WAIT_FALL: if (w_scl_fall) begin
            w_sda_oe_nxt = 1'b1;
            w_ph_nxt     = PH_DRIVE;
          end
          PH_DRIVE: if (w_scl_rise) w_ph_nxt = PH_HOLD;
          default: if (w_scl_fall) begin
            w_ph_nxt      = PH_WAIT_FALL;
            w_bit_cnt_nxt = 3'd0;
            if (r_rw) begin
              w_tx_nxt     = r_out;
              w_sda_oe_nxt = ~r_out[31];
              w_state_nxt  = S_RD;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = S_WR;
            end
          end
        endcase

        S_WR: if (w_scl_rise) begin
          w_shift_nxt   = w_byte;
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = S_WR_ACK;
            w_ph_nxt    = PH_WAIT_FALL;
          end
        end

        S_WR_ACK: unique case (r_ph)
          PH_WAIT_FALL: if (w_scl_fall) begin
            w_sda_oe_nxt = 1'b1;
            w_ph_nxt     = PH_DRIVE;
          end
          PH_DRIVE: if (w_scl_rise) begin
            w_out_nxt        = {r_out[23:0], r_shift};
            w_byte_cnt_nxt   = r_byte_cnt + 2'd1;
            w_word_valid_nxt = (r_byte_cnt == 2'd3);
            w_ph_nxt         = PH_HOLD;
          end
          default: if (w_scl_fall) begin
            w_sda_oe_nxt  = 1'b0;
            w_state_nxt   = S_WR;
            w_bit_cnt_nxt = 3'd0;
            w_ph_nxt      = PH_WAIT_FALL;
          end
        endcase

        // Bit 0 was already presented on entry; each later fall presents the
        // bit selected by the count of rises seen so far.
        S_RD: begin
          if (w_scl_fall) w_sda_oe_nxt = ~r_tx[w_rd_idx];
          if (w_scl_rise) begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_state_nxt = S_RD_ACK;
              w_ph_nxt    = PH_WAIT_FALL;
            end
          end
        end

        S_RD_ACK: unique case (r_ph)
          PH_WAIT_FALL: if (w_scl_fall) begin
            w_sda_oe_nxt = 1'b0;
            w_ph_nxt     = PH_DRIVE;
          end
          PH_DRIVE: if (w_scl_rise) begin
            if (r_sda_s2) begin
              w_state_nxt = S_IDLE;
              w_busy_nxt  = 1'b0;
            end else begin
              w_tx_nxt = {r_tx[23:0], r_tx[31:24]};
              w_ph_nxt = PH_HOLD;
            end
          end
          default: if (w_scl_fall) begin
            w_sda_oe_nxt  = ~r_tx[31];
            w_state_nxt   = S_RD;
            w_bit_cnt_nxt = 3'd0;
            w_ph_nxt      = PH_WAIT_FALL;
          end
        endcase

        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ph         <= PH_WAIT_FALL;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'h00;
      r_rw         <= 1'b0;
      r_byte_cnt   <= 2'd0;
      r_tx         <= 32'h0;
      r_sda_oe     <= 1'b0;
      r_out        <= 32'h0;
      r_word_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ph         <= w_ph_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_rw         <= w_rw_nxt;
      r_byte_cnt   <= w_byte_cnt_nxt;
      r_tx         <= w_tx_nxt;
      r_sda_oe     <= w_sda_oe_nxt;
      r_out        <= w_out_nxt;
      r_word_valid <= w_word_valid_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign sda_oe     = r_sda_oe;
  assign out        = r_out;
  assign word_valid = r_word_valid;
  assign busy       = r_busy;

endmodule
